// File: rtl/ex_muldiv_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, funct codes,
// mult/div engine state encoding and helpers.
package ex_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_op_t;

    // mult/multu/div/divu occupy 0x18..0x1B
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// 32-step sequential mult/div engine owning HI/LO. Only built when
// EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            idle_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_lo_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int CW = $clog2(ITER);

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              div_q, neg_lo_q, neg_hi_q, div0_q;

    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     sum, rtrial, diff;
    logic [XLEN-1:0]   hi_d, lo_d;

    // acc_q holds {partial/remainder, multiplier/quotient} while iterating
    always_comb begin
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        rtrial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff   = rtrial - {1'b0, opb_q};
        if (div_q)
            acc_d = diff[XLEN] ? {rtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
        else
            acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        if (div_q) begin
            lo_d = div0_q ? DIV0_QUO
                          : (neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
            hi_d = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
            lo_d = prod_fix[XLEN-1:0];
            hi_d = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start_i) begin
                    state_q  <= BUSY;
                    cnt_q    <= CW'(ITER - 1);
                    acc_q    <= {{XLEN{1'b0}}, abs32(a_i, op_i.is_signed)};
                    opb_q    <= abs32(b_i, op_i.is_signed);
                    div_q    <= op_i.is_div;
                    neg_lo_q <= op_i.is_signed & (a_i[XLEN-1] ^ b_i[XLEN-1]);
                    neg_hi_q <= op_i.is_signed & a_i[XLEN-1];
                    div0_q   <= (b_i == '0);
                end
                BUSY: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0)
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!abort_i) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o   = (state_q == IDLE);
    assign busy_o   = (state_q == BUSY);
    assign done_o   = (state_q == DONE);
    assign res_lo_o = lo_d;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule
`endif

// File: rtl/ex_muldiv_stage.sv
// MIPS execute stage: registered single-cycle ALU plus optional sequential
// mult/div engine with HI/LO (enabled by EX_MULDIV_EN).
module ex_muldiv_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            flush_in,
    input  logic [1:0]      alu_op_in,
    input  logic            alu_src_in,
    input  logic [XLEN-1:0] data1_in,
    input  logic [XLEN-1:0] data2_in,
    input  logic [XLEN-1:0] sign32_in,
    output logic [XLEN-1:0] result_out,
    output logic            zero_out,
    output logic            valid_out,
    output logic            stall_out,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);
    if (XLEN != 32 || ITER != XLEN) begin : g_cfg_err
        $error("ex_muldiv_stage: only XLEN = ITER = 32 is supported");
    end

    logic [XLEN-1:0] op_b, alu_res;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic            is_md, issue;
    logic            eng_idle, eng_done;
    logic [XLEN-1:0] eng_lo, hi_w, lo_w;

    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d, valid_q, valid_d;

    assign funct = sign32_in[5:0];
    assign shamt = sign32_in[10:6];
    assign op_b  = alu_src_in ? sign32_in : data2_in;

`ifdef EX_MULDIV_EN
    logic   eng_busy, md_start;
    md_op_t md_op;

    assign is_md    = (alu_op_in == ALUOP_FUNCT) && is_muldiv(funct);
    assign md_start = valid_in && !flush_in && is_md;
    assign md_op    = '{is_div: funct[1], is_signed: !funct[0]};

    muldiv_iter #(.XLEN(XLEN), .ITER(ITER)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .abort_i  (flush_in),
        .op_i     (md_op),
        .a_i      (data1_in),
        .b_i      (op_b),
        .idle_o   (eng_idle),
        .busy_o   (eng_busy),
        .done_o   (eng_done),
        .res_lo_o (eng_lo),
        .hi_o     (hi_w),
        .lo_o     (lo_w)
    );

    // DONE deliberately drops stall so upstream advances on the writeback edge
    assign stall_out = (eng_idle && md_start) || eng_busy;
`else
    assign is_md     = 1'b0;
    assign eng_idle  = 1'b1;
    assign eng_done  = 1'b0;
    assign eng_lo    = '0;
    assign hi_w      = '0;
    assign lo_w      = '0;
    assign stall_out = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        unique case (alu_op_in)
            ALUOP_ADD: alu_res = data1_in + op_b;
            ALUOP_SUB: alu_res = data1_in - op_b;
            ALUOP_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(data1_in) < $signed(op_b)};
            default: begin
                unique case (funct)
                    F_ADD:   alu_res = data1_in + op_b;
                    F_SUB:   alu_res = data1_in - op_b;
                    F_AND:   alu_res = data1_in & op_b;
                    F_OR:    alu_res = data1_in | op_b;
                    F_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(data1_in) < $signed(op_b)};
                    F_SLL:   alu_res = op_b << shamt;
                    F_SRL:   alu_res = op_b >> shamt;
                    F_MFHI:  alu_res = hi_w;
                    F_MFLO:  alu_res = lo_w;
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    // Only an idle engine accepts; the held instruction in DONE is not re-issued
    assign issue = valid_in && !flush_in && eng_idle;

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (eng_done && !flush_in) begin
            result_d = eng_lo;
            zero_d   = (eng_lo == '0);
            valid_d  = 1'b1;
        end else if (issue && !is_md) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign result_out = result_q;
    assign zero_out   = zero_q;
    assign valid_out  = valid_q;
    assign hi_out     = hi_w;
    assign lo_out     = lo_w;

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register; consumes its registered controls, operands and sign-extended immediate.
- Computes single-cycle ALU results with one registered cycle of latency.
- Runs MIPS mult/multu/div/divu as a 32-iteration sequential engine that owns the HI/LO registers.
- Back-pressures the IF/ID/ID-EX registers through stall_out while the engine is busy; results feed the EX/MEM register.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ITER, 32, mult/div iterations; equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction present from ID/EX
- flush_in  in  1  cancel the current instruction (branch taken or jump)
- alu_op_in  in  2  00 add, 01 sub, 10 funct-decoded, 11 slt
- alu_src_in  in  1  operand B select: 0 = data2_in, 1 = sign32_in
- data1_in  in  32  rs value
- data2_in  in  32  rt value
- sign32_in  in  32  sign-extended immediate; [5:0] = funct, [10:6] = shamt
- result_out  out  32  registered result
- zero_out  out  1  registered (result == 0)
- valid_out  out  1  result_out is valid this cycle
- stall_out  out  1  combinational; upstream registers hold while high
- hi_out  out  32  HI register
- lo_out  out  32  LO register

Behaviour:
- Reset: async on rst_n low. result_out=0, zero_out=0, valid_out=0, hi_out=0, lo_out=0, FSM=IDLE, counter=0.
- B = alu_src_in ? sign32_in : data2_in.
- Funct decode (alu_op_in = 10):
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - 0x00 sll B by shamt, 0x02 srl B by shamt.
  - 0x10 mfhi, 0x12 mflo.
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
  - Any other funct: result 0, valid_out still pulses.
- Arithmetic wraps modulo 2^32; no overflow trap.
- Single-cycle op (valid_in && !flush_in, FSM IDLE): result, zero and valid_out are registered at the next edge. valid_out is high for exactly one cycle.
- flush_in with valid_in in IDLE: valid_out=0 next cycle, no state change.
- FSM states: IDLE -> BUSY -> DONE -> IDLE.
- IDLE -> BUSY on a valid mult/div that is not flushed:
  - Latch operand magnitudes (absolute values for signed ops) and the result sign bits.
  - Counter loads 31.
  - stall_out goes high combinationally in that same cycle.
- BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle. Decrement the counter; go to DONE after the step taken at count 0, i.e. 32 steps.
- DONE: stall_out low, so upstream advances at this edge. At the edge:
  - Apply sign correction.
  - Write HI/LO: mult gives HI:LO = 64-bit product; div gives LO = quotient, HI = remainder (remainder takes the sign of the dividend).
  - result_out = new LO, valid_out = 1.
  - FSM returns to IDLE.
- stall_out = (IDLE && start) || BUSY.
- Latency: valid_out is asserted 34 cycles after the mult/div is first presented; stall_out is high for 33 cycles.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend; no exception.
- Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
- mfhi/mflo cannot issue while BUSY because stall holds them upstream. A mfhi/mflo in IDLE reads the current HI/LO.
- flush_in while BUSY/DONE: abort to IDLE at the next edge, HI/LO unchanged, valid_out=0.
- Reset mid-operation: abort, HI/LO cleared.
- The instruction still present on the inputs in the DONE cycle is never re-accepted.

Optional Feature:
- EX_MULDIV_EN.
- Defined: engine, HI/LO and the full behaviour above are present.
- Undefined: functs 0x18-0x1B, 0x10 and 0x12 give result 0 with a single-cycle valid_out. stall_out is tied 0, hi_out/lo_out are tied 0, and no FSM is synthesized.

Decomposition:
- Shared package ex_pkg holds:
  - ALU op codes (ALUOP_ADD/SUB/FUNCT/SLT).
  - Funct constants.
  - FSM state encoding (IDLE/BUSY/DONE).
  - Divide-by-zero constant.
- One sub-module, muldiv_iter: the FSM, counter, shift datapath and HI/LO, with a start/done/abort interface.
- ALU decode stays in ex_muldiv_stage.

Test Plan:
- Reset, then add: data1=5, data2=7, op 10, funct 0x20 -> next cycle result_out=12, valid_out=1, zero_out=0.
- Branch compare: op 01, data1=data2=0x1234 -> result_out=0, zero_out=1.
- Signed mult: -3 × 7 -> stall_out high 33 cycles; at cycle 34 HI=0xFFFFFFFF, LO=0xFFFFFFEB, valid_out=1. A following mflo returns 0xFFFFFFEB.
- Signed div: -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divu 9/0 -> LO=0xFFFFFFFF, HI=9.
- flush_in asserted at BUSY cycle 10 of a multu -> stall_out low the next cycle, HI/LO unchanged, no valid_out.
- rst_n low at BUSY cycle 5 -> all outputs 0 immediately, FSM IDLE. With EX_MULDIV_EN undefined, mult -> result 0, no stall.
